// File: rtl/muldiv_pkg.sv
// Shared opcodes, FSM encoding and flag bit positions for the multi-cycle mul/div sequencer.
package muldiv_pkg;

  localparam int CNT_W = 6;

  localparam logic [3:0] OP_MUL = 4'b0110;
  localparam logic [3:0] OP_MLA = 4'b0111;
  localparam logic [3:0] OP_MLS = 4'b1000;
  localparam logic [3:0] OP_DIV = 4'b1001;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Flags = {DivZero, N, Z}
  localparam int FLAG_Z  = 0;
  localparam int FLAG_N  = 1;
  localparam int FLAG_DZ = 2;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_MLA) || (op == OP_MLS) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: a shift-add multiply step and a restoring divide step side by side.
// The sequencer selects which result to register based on the latched op.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  input  logic [WIDTH-1:0]   i_rem,
  input  logic [WIDTH-1:0]   i_quo,
  input  logic [WIDTH-1:0]   i_divisor,
  output logic [2*WIDTH-1:0] o_acc,
  output logic [2*WIDTH-1:0] o_mcand,
  output logic [WIDTH-1:0]   o_mplier,
  output logic [WIDTH-1:0]   o_rem,
  output logic [WIDTH-1:0]   o_quo
);

  logic [WIDTH:0] w_shift;
  logic           w_ge;

  // Remainder shifts left taking the next dividend bit from the top of the quotient register.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, i_divisor});

  always_comb begin
    o_acc    = i_mplier[0] ? (i_acc + i_mcand) : i_acc;
    o_mcand  = i_mcand << 1;
    o_mplier = i_mplier >> 1;
    if (w_ge) begin
      o_rem = WIDTH'(w_shift - {1'b0, i_divisor});
      o_quo = {i_quo[WIDTH-2:0], 1'b1};
    end else begin
      o_rem = w_shift[WIDTH-1:0];
      o_quo = {i_quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MUL/MLA/MLS/DIV sequencer holding the pipeline with Stall until Done.
// MULDIV_EARLY_TERM_EN: multiply iterations stop once the remaining multiplier bits are zero.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic             Flush,
  input  logic [3:0]       ALUControl,
  input  logic             Unsigned,
  input  logic             Long,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic             Busy,
  output logic             Stall,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic [WIDTH-1:0] Result2,
  output logic [2:0]       Flags
);

  state_t r_state, w_next;

  logic [3:0]         r_op;
  logic               r_uns, r_long;
  logic [WIDTH-1:0]   r_a, r_b, r_c, r_d;
  logic               r_res_sign, r_div_sign;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc, r_mcand;
  logic [WIDTH-1:0]   r_mplier, r_rem, r_quo;
  logic [WIDTH-1:0]   r_result, r_result2;
  logic [2:0]         r_flags;

  logic               w_accept;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic               w_is_div;
  logic               w_last_iter;
  logic               w_early_exit, w_prep_skip;
  logic [2*WIDTH-1:0] w_acc_n, w_mcand_n;
  logic [WIDTH-1:0]   w_mplier_n, w_rem_n, w_quo_n;
  logic [2*WIDTH-1:0] w_prod, w_full;
  logic               w_wide;
  logic [WIDTH-1:0]   w_fix_res, w_fix_res2;
  logic [2:0]         w_fix_flags;

  assign w_accept = (r_state == ST_IDLE) && Start && is_legal_op(ALUControl);
  assign w_is_div = (r_op == OP_DIV);

  assign w_a_neg = !r_uns && r_a[WIDTH-1];
  assign w_b_neg = !r_uns && r_b[WIDTH-1];
  assign w_abs_a = w_a_neg ? (-r_a) : r_a;
  assign w_abs_b = w_b_neg ? (-r_b) : r_b;

  assign w_last_iter = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MULDIV_EARLY_TERM_EN
  assign w_early_exit = !w_is_div && (w_mplier_n == '0);
  assign w_prep_skip  = !w_is_div && (w_abs_b == '0);
`else
  assign w_early_exit = 1'b0;
  assign w_prep_skip  = 1'b0;
`endif

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc     (r_acc),
    .i_mcand   (r_mcand),
    .i_mplier  (r_mplier),
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_mplier),
    .o_acc     (w_acc_n),
    .o_mcand   (w_mcand_n),
    .o_mplier  (w_mplier_n),
    .o_rem     (w_rem_n),
    .o_quo     (w_quo_n)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (Flush && (r_state != ST_IDLE)) begin
      w_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) w_next = ST_PREP;
        ST_PREP: w_next = w_prep_skip ? ST_FIX : ST_ITER;
        ST_ITER: if (w_last_iter || w_early_exit) w_next = ST_FIX;
        ST_FIX:  w_next = ST_DONE;
        ST_DONE: w_next = ST_IDLE;
        default: w_next = ST_IDLE;
      endcase
    end
  end

  assign Busy  = (r_state != ST_IDLE);
  assign Done  = (r_state == ST_DONE);
  assign Stall = (Start && (r_state == ST_IDLE)) || (Busy && !Done);

  // Sign correction and accumulate/subtract, evaluated during FIX.
  always_comb begin
    w_prod      = r_res_sign ? (-r_acc) : r_acc;
    w_full      = '0;
    w_wide      = r_long && ((r_op == OP_MUL) || (r_op == OP_MLA));
    w_fix_res   = '0;
    w_fix_res2  = '0;
    w_fix_flags = '0;
    case (r_op)
      OP_MUL:  w_full = w_prod;
      OP_MLA:  w_full = w_prod + (r_long ? {r_d, r_c} : {{WIDTH{1'b0}}, r_c});
      OP_MLS:  w_full = {{WIDTH{1'b0}}, r_c - w_prod[WIDTH-1:0]};
      default: w_full = '0;
    endcase
    if (w_is_div) begin
      if (r_b == '0) begin
        w_fix_res            = '0;
        w_fix_res2           = r_a;
        w_fix_flags[FLAG_DZ] = 1'b1;
      end else begin
        w_fix_res  = r_res_sign ? (-r_quo) : r_quo;
        w_fix_res2 = r_div_sign ? (-r_rem) : r_rem;
      end
      w_fix_flags[FLAG_N] = w_fix_res[WIDTH-1];
      w_fix_flags[FLAG_Z] = (w_fix_res == '0);
    end else begin
      w_fix_res  = w_full[WIDTH-1:0];
      w_fix_res2 = w_wide ? w_full[2*WIDTH-1:WIDTH] : '0;
      if (w_wide) begin
        w_fix_flags[FLAG_N] = w_full[2*WIDTH-1];
        w_fix_flags[FLAG_Z] = (w_full == '0);
      end else begin
        w_fix_flags[FLAG_N] = w_fix_res[WIDTH-1];
        w_fix_flags[FLAG_Z] = (w_fix_res == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op       <= '0;
      r_uns      <= 1'b0;
      r_long     <= 1'b0;
      r_a        <= '0;
      r_b        <= '0;
      r_c        <= '0;
      r_d        <= '0;
      r_res_sign <= 1'b0;
      r_div_sign <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_result   <= '0;
      r_result2  <= '0;
      r_flags    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op   <= ALUControl;
            r_uns  <= Unsigned;
            r_long <= Long;
            r_a    <= a;
            r_b    <= b;
            r_c    <= c;
            r_d    <= d;
          end
        end
        ST_PREP: begin
          // r_mplier doubles as the divisor; r_quo starts as the dividend and fills with quotient bits.
          r_res_sign <= w_a_neg ^ w_b_neg;
          r_div_sign <= w_a_neg;
          r_cnt      <= '0;
          r_acc      <= '0;
          r_mcand    <= {{WIDTH{1'b0}}, w_abs_a};
          r_mplier   <= w_abs_b;
          r_rem      <= '0;
          r_quo      <= w_abs_a;
        end
        ST_ITER: begin
          r_cnt <= r_cnt + 1'b1;
          if (w_is_div) begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
          end else begin
            r_acc    <= w_acc_n;
            r_mcand  <= w_mcand_n;
            r_mplier <= w_mplier_n;
          end
        end
        ST_FIX: begin
          if (!Flush) begin
            r_result  <= w_fix_res;
            r_result2 <= w_fix_res2;
            r_flags   <= w_fix_flags;
          end
        end
        default: ;
      endcase
    end
  end

  assign Result  = r_result;
  assign Result2 = r_result2;
  assign Flags   = r_flags;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic results, flags, latency, flush and reset behaviour.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic        Flush = 1'b0;
  logic [3:0]  ALUControl = 4'b0;
  logic        Unsigned = 1'b0;
  logic        Long = 1'b0;
  logic [31:0] a = '0, b = '0, c = '0, d = '0;
  logic        Busy, Stall, Done;
  logic [31:0] Result, Result2;
  logic [2:0]  Flags;

  int checks = 0;
  int errors = 0;

  int   g_lat;
  logic g_stall0, g_busy1, g_stall_prev, g_stall_done;

`ifdef MULDIV_EARLY_TERM_EN
  localparam int LAT_MUL76 = 6;
  localparam int LAT_MUL53 = 5;
`else
  localparam int LAT_MUL76 = 35;
  localparam int LAT_MUL53 = 35;
`endif

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Start(Start), .Flush(Flush),
    .ALUControl(ALUControl), .Unsigned(Unsigned), .Long(Long),
    .a(a), .b(b), .c(c), .d(d),
    .Busy(Busy), .Stall(Stall), .Done(Done),
    .Result(Result), .Result2(Result2), .Flags(Flags)
  );

  always #5 clk = ~clk;

  // Start is raised in cycle 0; g_lat is the cycle in which Done is seen.
  task automatic run_op(input logic [3:0] op, input logic uns, input logic lng,
                        input logic [31:0] ia, input logic [31:0] ib,
                        input logic [31:0] ic, input logic [31:0] id);
    int cyc;
    @(negedge clk);
    ALUControl = op; Unsigned = uns; Long = lng;
    a = ia; b = ib; c = ic; d = id;
    Start = 1'b1;
    #1 g_stall0 = Stall;
    cyc = 0;
    g_lat = -1;
    g_busy1 = 1'b0;
    g_stall_prev = 1'b0;
    g_stall_done = 1'b1;
    while (cyc < 100 && g_lat < 0) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        Start = 1'b0;
        g_busy1 = Busy;
      end
      if (Done) begin
        g_lat = cyc;
        g_stall_done = Stall;
      end else begin
        g_stall_prev = Stall;
      end
    end
    if (g_lat < 0) begin
      checks++; errors++;
      $display("FAIL op_timeout: Done not seen within 100 cycles, required a Done pulse");
    end
  endtask

  task automatic test_reset();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", Busy); end
    checks++; if (Stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", Stall); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", Done); end
    checks++; if ({Result, Result2, Flags} !== 67'd0) begin errors++;
      $display("FAIL reset_outputs: got %h %h %b required zeros", Result, Result2, Flags); end
  endtask

  task automatic test_mul_unsigned();
    run_op(4'b0110, 1'b1, 1'b0, 32'd7, 32'd6, 32'd0, 32'd0);
    checks++; if (g_lat !== LAT_MUL76) begin errors++; $display("FAIL mul_u_latency: got %0d required %0d", g_lat, LAT_MUL76); end
    checks++; if (g_stall0 !== 1'b1) begin errors++; $display("FAIL mul_u_stall_c0: got %b required 1", g_stall0); end
    checks++; if (g_busy1 !== 1'b1) begin errors++; $display("FAIL mul_u_busy_c1: got %b required 1", g_busy1); end
    checks++; if (g_stall_prev !== 1'b1) begin errors++; $display("FAIL mul_u_stall_fix: got %b required 1", g_stall_prev); end
    checks++; if (g_stall_done !== 1'b0) begin errors++; $display("FAIL mul_u_stall_done: got %b required 0", g_stall_done); end
    checks++; if (Result !== 32'd42) begin errors++; $display("FAIL mul_u_result: got %h required %h", Result, 32'd42); end
    checks++; if (Result2 !== 32'd0) begin errors++; $display("FAIL mul_u_result2: got %h required 0", Result2); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("FAIL mul_u_flags: got %b required 000", Flags); end
  endtask

  task automatic test_smull();
    run_op(4'b0110, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0);
    checks++; if ({Result2, Result} !== 64'hFFFF_FFFF_FFFF_FFF1) begin errors++;
      $display("FAIL smull_result: got %h_%h required FFFFFFFF_FFFFFFF1", Result2, Result); end
    checks++; if (Flags !== 3'b010) begin errors++; $display("FAIL smull_flags: got %b required 010", Flags); end
  endtask

  task automatic test_mla();
    run_op(4'b0111, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'd0);
    checks++; if ({Result2, Result} !== 64'h0000_0001_FFFF_FFFF) begin errors++;
      $display("FAIL mla_long_result: got %h_%h required 00000001_FFFFFFFF", Result2, Result); end
    checks++; if (Flags !== 3'b000) begin errors++; $display("FAIL mla_long_flags: got %b required 000", Flags); end
    // -2 * 3 + 6 = 0, short signed MLA exercises the Z flag
    run_op(4'b0111, 1'b0, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'd6, 32'hDEAD_BEEF);
    checks++; if ({Result2, Result, Flags} !== {64'd0, 3'b001}) begin errors++;
      $display("FAIL mla_short_zero: got %h %h %b required 0 0 001", Result2, Result, Flags); end
  endtask

  task automatic test_mls();
    run_op(4'b1000, 1'b0, 1'b1, 32'hFFFF_FFFD, 32'd4, 32'd5, 32'd0);
    checks++; if ({Result2, Result, Flags} !== {32'd0, 32'd17, 3'b000}) begin errors++;
      $display("FAIL mls_signed: got %h %h %b required 0 11 000", Result2, Result, Flags); end
  endtask

  task automatic test_div();
    run_op(4'b1001, 1'b0, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0);
    checks++; if ({Result, Result2} !== {32'hFFFF_FFFD, 32'hFFFF_FFFF}) begin errors++;
      $display("FAIL div_signed: got %h %h required FFFFFFFD FFFFFFFF", Result, Result2); end
    checks++; if (Flags !== 3'b010) begin errors++; $display("FAIL div_signed_flags: got %b required 010", Flags); end
    run_op(4'b1001, 1'b1, 1'b0, 32'd9, 32'd0, 32'd0, 32'd0);
    checks++; if (g_lat !== 35) begin errors++; $display("FAIL div_zero_latency: got %0d required 35", g_lat); end
    checks++; if ({Result, Result2, Flags} !== {32'd0, 32'd9, 3'b101}) begin errors++;
      $display("FAIL div_zero: got %h %h %b required 0 9 101", Result, Result2, Flags); end
    run_op(4'b1001, 1'b0, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0);
    checks++; if ({Result, Result2, Flags} !== {32'h8000_0000, 32'd0, 3'b010}) begin errors++;
      $display("FAIL div_overflow: got %h %h %b required 80000000 0 010", Result, Result2, Flags); end
  endtask

  task automatic test_back_to_back();
    run_op(4'b1001, 1'b1, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0);
    checks++; if ({Result, Result2} !== {32'd14, 32'd2}) begin errors++;
      $display("FAIL b2b_first: got %h %h required E 2", Result, Result2); end
    run_op(4'b0110, 1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0);
    checks++; if (g_stall0 !== 1'b1 || g_busy1 !== 1'b1) begin errors++;
      $display("FAIL b2b_accept: got stall0=%b busy1=%b required 1 1", g_stall0, g_busy1); end
    checks++; if ({Result2, Result, Flags} !== {32'd1, 32'd0, 3'b000}) begin errors++;
      $display("FAIL b2b_second: got %h %h %b required 1 0 000", Result2, Result, Flags); end
  endtask

  task automatic test_illegal();
    @(negedge clk);
    ALUControl = 4'b0010; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL illegal_op_busy: got %b required 0", Busy); end
  endtask

  task automatic test_flush();
    int cyc, done_cyc;
    logic [31:0] prev;
    prev = Result;
    @(negedge clk);
    ALUControl = 4'b1001; Unsigned = 1'b1; Long = 1'b0;
    a = 32'd1000; b = 32'd3; Start = 1'b1;
    cyc = 0;
    done_cyc = -1;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) Start = 1'b0;
      if (cyc == 10) Flush = 1'b1;
      if (cyc == 11) begin
        Flush = 1'b0;
        checks++; if (Busy !== 1'b0 || Result !== prev) begin errors++;
          $display("FAIL flush_abort: got busy=%b result=%h required 0 %h", Busy, Result, prev); end
      end
      if (cyc == 12) begin a = 32'd50; b = 32'd7; Start = 1'b1; end
      if (cyc == 13) Start = 1'b0;
      if (Done && done_cyc < 0) done_cyc = cyc;
    end
    checks++; if (done_cyc !== 47) begin errors++; $display("FAIL flush_done_cycle: got %0d required 47", done_cyc); end
    checks++; if ({Result, Result2} !== {32'd7, 32'd1}) begin errors++;
      $display("FAIL flush_second_result: got %h %h required 7 1", Result, Result2); end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    @(negedge clk);
    ALUControl = 4'b1001; Unsigned = 1'b1; a = 32'd81; b = 32'd9; Start = 1'b1;
    for (cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 1) Start = 1'b0;
    end
    reset = 1'b0;
    #1;
    checks++; if ({Busy, Stall, Done} !== 3'b000) begin errors++;
      $display("FAIL reset_mid_ctrl: got busy=%b stall=%b done=%b required 000", Busy, Stall, Done); end
    checks++; if ({Result, Result2, Flags} !== 67'd0) begin errors++;
      $display("FAIL reset_mid_outputs: got %h %h %b required zeros", Result, Result2, Flags); end
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (Done || Busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_done: got %0d active cycles required 0", seen); end
  endtask

  task automatic test_early_term();
    run_op(4'b0110, 1'b1, 1'b0, 32'd5, 32'd3, 32'd0, 32'd0);
    checks++; if (g_lat !== LAT_MUL53) begin errors++; $display("FAIL mul53_latency: got %0d required %0d", g_lat, LAT_MUL53); end
    checks++; if (Result !== 32'd15) begin errors++; $display("FAIL mul53_result: got %h required F", Result); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_mul_unsigned();
    test_smull();
    test_mla();
    test_mls();
    test_div();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    test_early_term();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
